// File: rtl/vai_rx_demux_if.sv
// One CCI-P Rx bundle per lane; N=1 for the upstream port, N=NUM_SUB_AFUS for the fan-out.
// MMIO data travels in c0Data, as on the real Rx channel.
interface vai_rx_demux_if #(
    parameter int N      = 1,
    parameter int DATA_W = 512
) ();
    logic [N-1:0]             c0TxAlmFull;
    logic [N-1:0]             c1TxAlmFull;
    logic [N-1:0]             c0RspValid;
    logic [N-1:0][3:0]        c0RespType;
    logic [N-1:0][1:0]        c0ClNum;
    logic [N-1:0][15:0]       c0Mdata;
    logic [N-1:0][DATA_W-1:0] c0Data;
    logic [N-1:0]             c0MmioRdValid;
    logic [N-1:0]             c0MmioWrValid;
    logic [N-1:0][15:0]       c0MmioAddr;
    logic [N-1:0][8:0]        c0MmioTid;
    logic [N-1:0]             c1RspValid;
    logic [N-1:0][3:0]        c1RespType;
    logic [N-1:0]             c1Format;
    logic [N-1:0][1:0]        c1ClNum;
    logic [N-1:0][15:0]       c1Mdata;

    modport master (
        output c0TxAlmFull, c1TxAlmFull, c0RspValid, c0RespType, c0ClNum, c0Mdata, c0Data,
               c0MmioRdValid, c0MmioWrValid, c0MmioAddr, c0MmioTid,
               c1RspValid, c1RespType, c1Format, c1ClNum, c1Mdata
    );
    modport slave (
        input  c0TxAlmFull, c1TxAlmFull, c0RspValid, c0RespType, c0ClNum, c0Mdata, c0Data,
               c0MmioRdValid, c0MmioWrValid, c0MmioAddr, c0MmioTid,
               c1RspValid, c1RespType, c1Format, c1ClNum, c1Mdata
    );
endinterface

// File: rtl/vai_rx_demux.sv
// Steers upstream CCI-P Rx responses/MMIO to sub-AFUs and tracks outstanding requests per sub-AFU.
// Drain FSM (one per sub-AFU):
//   state      | meaning
//   IDLE       | normal routing
//   DRAIN      | port outputs suppressed, waiting for rd/wr counts to reach 0
//   DONE       | drain_done pulse (one cycle), still suppressed
//   DRAIN_HOLD | drained but drain_req still high; suppressed until it falls
module vai_rx_demux #(
    parameter int NUM_SUB_AFUS  = 8,
    parameter int CNT_W         = 10,
    parameter int MMIO_WIN_BITS = 12
) (
    input  logic                    pClk,
    input  logic                    SoftReset_n,
    vai_rx_demux_if.slave           up_RxPort,
    vai_rx_demux_if.master          afu_RxPort,
    input  logic [NUM_SUB_AFUS-1:0] rd_issue,
    input  logic [NUM_SUB_AFUS-1:0] wr_issue,
    input  logic [NUM_SUB_AFUS-1:0] drain_req,
    output logic [NUM_SUB_AFUS-1:0] drain_done,
    output logic [NUM_SUB_AFUS-1:0] underflow_err,
    output logic [15:0]             bad_tag_cnt
);
    localparam int          N          = NUM_SUB_AFUS;
    localparam int          IDX_W      = 16 - MMIO_WIN_BITS;
    localparam logic [15:0] WIN_MASK   = 16'((32'd1 << MMIO_WIN_BITS) - 32'd1);
    localparam logic [3:0]  RSP_RDLINE = 4'h0;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DRAIN      = 2'd1,
        DONE       = 2'd2,
        DRAIN_HOLD = 2'd3
    } drainState_e;

    drainState_e      state     [N];
    drainState_e      stateNext [N];
    logic [CNT_W-1:0] rdCnt     [N];
    logic [CNT_W-1:0] rdCntNext [N];
    logic [CNT_W-1:0] wrCnt     [N];
    logic [CNT_W-1:0] wrCntNext [N];
    logic [N-1:0]     rdErr, wrErr, suppress, c0Sel, c1Sel, mmioSel;

    logic [3:0]       c0Idx, c1Idx;
    logic [IDX_W-1:0] mmioIdx;
    logic             c0Hit, c1Hit, mmioHit;
    logic [2:0]       badInc;
    logic [16:0]      badSum;

    // Returns {error, new count}; error flags both clamp-at-0 and saturate-at-max.
    function automatic logic [CNT_W:0] cntUpdate(input logic [CNT_W-1:0] cnt,
                                                 input logic inc, input logic [2:0] dec);
        logic [CNT_W+1:0] sum;
        logic [CNT_W+1:0] decW;
        sum  = {2'b00, cnt} + {{(CNT_W+1){1'b0}}, inc};
        decW = {{(CNT_W-1){1'b0}}, dec};
        if (sum < decW) return {1'b1, {CNT_W{1'b0}}};
        sum = sum - decW;
        if (sum > {2'b00, {CNT_W{1'b1}}}) return {1'b1, {CNT_W{1'b1}}};
        return {1'b0, sum[CNT_W-1:0]};
    endfunction

    assign c0Idx   = up_RxPort.c0Mdata[0][15:12];
    assign c1Idx   = up_RxPort.c1Mdata[0][15:12];
    assign mmioIdx = up_RxPort.c0MmioAddr[0][15:MMIO_WIN_BITS];
    assign c0Hit   = int'(c0Idx) < N;
    assign c1Hit   = int'(c1Idx) < N;
    assign mmioHit = int'(mmioIdx) < N;

    assign badInc = 3'(up_RxPort.c0RspValid[0] & ~c0Hit)
                  + 3'(up_RxPort.c0MmioRdValid[0] & ~mmioHit)
                  + 3'(up_RxPort.c0MmioWrValid[0] & ~mmioHit)
                  + 3'(up_RxPort.c1RspValid[0] & ~c1Hit);
    assign badSum = {1'b0, bad_tag_cnt} + 17'(badInc);

    always_comb begin
        c0Sel   = '0;
        c1Sel   = '0;
        mmioSel = '0;
        for (int i = 0; i < N; i++) begin
            c0Sel[i]   = up_RxPort.c0RspValid[0] && c0Hit && (c0Idx == 4'(i));
            c1Sel[i]   = up_RxPort.c1RspValid[0] && c1Hit && (c1Idx == 4'(i));
            mmioSel[i] = mmioHit && (mmioIdx == IDX_W'(i));
        end
    end

    always_comb begin
        rdErr = '0;
        wrErr = '0;
        for (int i = 0; i < N; i++) begin
            {rdErr[i], rdCntNext[i]} = cntUpdate(rdCnt[i], rd_issue[i],
                {2'b00, c0Sel[i] && (up_RxPort.c0RespType[0] == RSP_RDLINE)});
            // Packed c1 responses retire cl_num+1 lines at once.
            {wrErr[i], wrCntNext[i]} = cntUpdate(wrCnt[i], wr_issue[i],
                !c1Sel[i] ? 3'd0 :
                (up_RxPort.c1Format[0] ? ({1'b0, up_RxPort.c1ClNum[0]} + 3'd1) : 3'd1));
        end
    end

    always_comb begin
        suppress   = '0;
        drain_done = '0;
        for (int i = 0; i < N; i++) begin
            stateNext[i]  = state[i];
            suppress[i]   = (state[i] != IDLE);
            drain_done[i] = (state[i] == DONE);
            case (state[i])
                IDLE:       if (drain_req[i]) stateNext[i] = DRAIN;
                DRAIN:      if (rdCntNext[i] == '0 && wrCntNext[i] == '0) stateNext[i] = DONE;
                DONE:       stateNext[i] = drain_req[i] ? DRAIN_HOLD : IDLE;
                DRAIN_HOLD: if (!drain_req[i]) stateNext[i] = IDLE;
                default:    stateNext[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge pClk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            for (int i = 0; i < N; i++) begin
                state[i] <= IDLE;
                rdCnt[i] <= '0;
                wrCnt[i] <= '0;
            end
            underflow_err              <= '0;
            bad_tag_cnt                <= '0;
            afu_RxPort.c0RspValid      <= '0;
            afu_RxPort.c0MmioRdValid   <= '0;
            afu_RxPort.c0MmioWrValid   <= '0;
            afu_RxPort.c1RspValid      <= '0;
            afu_RxPort.c0TxAlmFull     <= '1;
            afu_RxPort.c1TxAlmFull     <= '1;
        end else begin
            for (int i = 0; i < N; i++) begin
                state[i] <= stateNext[i];
                rdCnt[i] <= rdCntNext[i];
                wrCnt[i] <= wrCntNext[i];
                afu_RxPort.c0RspValid[i]    <= c0Sel[i] && !suppress[i];
                afu_RxPort.c1RspValid[i]    <= c1Sel[i] && !suppress[i];
                afu_RxPort.c0MmioRdValid[i] <= up_RxPort.c0MmioRdValid[0] && mmioSel[i] && !suppress[i];
                afu_RxPort.c0MmioWrValid[i] <= up_RxPort.c0MmioWrValid[0] && mmioSel[i] && !suppress[i];
            end
            underflow_err          <= underflow_err | rdErr | wrErr;
            bad_tag_cnt            <= badSum[16] ? 16'hFFFF : badSum[15:0];
            afu_RxPort.c0TxAlmFull <= {N{up_RxPort.c0TxAlmFull[0]}};
            afu_RxPort.c1TxAlmFull <= {N{up_RxPort.c1TxAlmFull[0]}};
        end
    end

    // Payload is broadcast; only the valid bits select the owning port.
    always_ff @(posedge pClk) begin
        for (int i = 0; i < N; i++) begin
            afu_RxPort.c0RespType[i] <= up_RxPort.c0RespType[0];
            afu_RxPort.c0ClNum[i]    <= up_RxPort.c0ClNum[0];
            afu_RxPort.c0Mdata[i]    <= up_RxPort.c0Mdata[0];
            afu_RxPort.c0Data[i]     <= up_RxPort.c0Data[0];
            afu_RxPort.c0MmioAddr[i] <= up_RxPort.c0MmioAddr[0] & WIN_MASK;
            afu_RxPort.c0MmioTid[i]  <= up_RxPort.c0MmioTid[0];
            afu_RxPort.c1RespType[i] <= up_RxPort.c1RespType[0];
            afu_RxPort.c1Format[i]   <= up_RxPort.c1Format[0];
            afu_RxPort.c1ClNum[i]    <= up_RxPort.c1ClNum[0];
            afu_RxPort.c1Mdata[i]    <= up_RxPort.c1Mdata[0];
        end
    end
endmodule
